// File: rtl/debounce_sync.sv
// Raw-input conditioner: SYNC_STAGES-flop synchronizer followed by a counter-based debounce FSM.
// Define DEBOUNCE_SYNC_GLITCH_CNT_EN to add a saturating count of rejected glitches (glitch_cnt).
module debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       sample_en,
  output logic       dout,
  output logic       rise,
  output logic       fall,
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  output logic [7:0] glitch_cnt,
`endif
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("debounce_sync: DEBOUNCE_CYCLES must be >= 2");
  end

  typedef enum logic {STABLE, QUALIFY} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic                   dout_nx, rise_nx, fall_nx;

  // Synchronizer free-runs; sample_en only gates the FSM.
  always_ff @(posedge clk) begin
    if (rst) sync <= {SYNC_STAGES{RESET_LEVEL}};
    else     sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      dout  <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dout  <= dout_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
      busy  <= (state_nx == QUALIFY);
    end
  end

  // Pulses default low every clock so they last one clk even with sparse sample_en.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dout_nx  = dout;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    if (sample_en) begin
      case (state)
        STABLE: begin
          if (s != dout) begin
            state_nx = QUALIFY;
            cnt_nx   = CW'(1);
          end else begin
            cnt_nx   = '0;
          end
        end
        QUALIFY: begin
          if (s == dout) begin
            state_nx = STABLE;
            cnt_nx   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nx = STABLE;
            cnt_nx   = '0;
            dout_nx  = s;
            rise_nx  = s;
            fall_nx  = ~s;
          end else begin
            cnt_nx   = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  logic glitch;
  assign glitch = sample_en && (state == QUALIFY) && (s == dout);

  always_ff @(posedge clk) begin
    if (rst)                               glitch_cnt <= 8'h00;
    else if (glitch && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'h01;
  end
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync (default parameters: 2 sync stages, 4 debounce samples, reset level 0).
module tb_debounce_sync;

  logic clk, rst, din, sample_en;
  logic dout, rise, fall, busy;
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .sample_en (sample_en),
    .dout      (dout),
    .rise      (rise),
    .fall      (fall),
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    .glitch_cnt(glitch_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied before edge i, outputs {dout,rise,fall,busy} expected after edge i.
  typedef struct packed {
    logic       rst;
    logic       din;
    logic       en;
    logic [3:0] exp;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic d, input logic e, input logic [3:0] o);
    vec_t v;
    v.rst = r; v.din = d; v.en = e; v.exp = o;
    return v;
  endfunction

  task automatic tick(input logic r, input logic d, input logic e);
    rst = r; din = d; sample_en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {4'b0, dout, rise, fall, busy};
  endfunction

  initial begin
    int rise_cnt;
    logic [3:0] e4;

    // reset with din high, then rise after 5 edges
    vecs[0]  = mk(1, 1, 1, 4'b0000);
    vecs[1]  = mk(1, 1, 1, 4'b0000);
    vecs[2]  = mk(0, 1, 1, 4'b0000);
    vecs[3]  = mk(0, 1, 1, 4'b0000);
    vecs[4]  = mk(0, 1, 1, 4'b0001);
    vecs[5]  = mk(0, 1, 1, 4'b0001);
    vecs[6]  = mk(0, 1, 1, 4'b0001);
    vecs[7]  = mk(0, 1, 1, 4'b1100);
    vecs[8]  = mk(0, 1, 1, 4'b1000);
    // release: fall after 5 edges, busy drops with it
    vecs[9]  = mk(0, 0, 1, 4'b1000);
    vecs[10] = mk(0, 0, 1, 4'b1000);
    vecs[11] = mk(0, 0, 1, 4'b1001);
    vecs[12] = mk(0, 0, 1, 4'b1001);
    vecs[13] = mk(0, 0, 1, 4'b1001);
    vecs[14] = mk(0, 0, 1, 4'b0010);
    vecs[15] = mk(0, 0, 1, 4'b0000);
    // two-cycle glitch: busy pulses, no edge
    vecs[16] = mk(0, 1, 1, 4'b0000);
    vecs[17] = mk(0, 1, 1, 4'b0000);
    vecs[18] = mk(0, 0, 1, 4'b0001);
    vecs[19] = mk(0, 0, 1, 4'b0001);
    vecs[20] = mk(0, 0, 1, 4'b0000);
    vecs[21] = mk(0, 0, 1, 4'b0000);
    // sample_en gating: FSM holds, rise still one clk wide
    vecs[22] = mk(0, 1, 0, 4'b0000);
    vecs[23] = mk(0, 1, 0, 4'b0000);
    vecs[24] = mk(0, 1, 0, 4'b0000);
    vecs[25] = mk(0, 1, 1, 4'b0001);
    vecs[26] = mk(0, 1, 0, 4'b0001);
    vecs[27] = mk(0, 1, 1, 4'b0001);
    vecs[28] = mk(0, 1, 1, 4'b0001);
    vecs[29] = mk(0, 1, 1, 4'b1100);
    vecs[30] = mk(0, 1, 0, 4'b1000);
    vecs[31] = mk(0, 1, 0, 4'b1000);

    rst = 1'b1; din = 1'b0; sample_en = 1'b1;
    #2;
    for (int i = 0; i < NV; i++) begin
      tick(vecs[i].rst, vecs[i].din, vecs[i].en);
      chk($sformatf("vec%0d", i), outs(), {4'b0, vecs[i].exp});
    end
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    chk("glitch_cnt_one", glitch_cnt, 8'd1);
`endif

    // prescaled: sample_en every 4th clock, din 0->1
    tick(1, 0, 1);
    tick(1, 0, 1);
    chk("pre_reset", outs(), 8'h00);
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    chk("glitch_cnt_rst", glitch_cnt, 8'd0);
`endif
    rise_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick(0, 1, (c % 4) == 3);
      e4 = {c >= 15, c == 15, 1'b0, (c >= 3) && (c < 15)};
      chk($sformatf("presc_c%0d", c), outs(), {4'b0, e4});
      if (rise) rise_cnt++;
    end
    chk("presc_rise_width", 8'(rise_cnt), 8'd1);

    // reset while qualifying a fall with counter at 2
    tick(0, 0, 1); chk("mid_e0", outs(), 8'h08);
    tick(0, 0, 1); chk("mid_e1", outs(), 8'h08);
    tick(0, 0, 1); chk("mid_e2", outs(), 8'h09);
    tick(0, 0, 1); chk("mid_e3", outs(), 8'h09);
    tick(1, 0, 1); chk("mid_rst", outs(), 8'h00);
    for (int c = 0; c < 6; c++) begin
      tick(0, 0, 1);
      chk($sformatf("mid_post%0d", c), outs(), 8'h00);
    end

`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    chk("glitch_cnt_mid", glitch_cnt, 8'd0);
    for (int g = 0; g < 305; g++) begin
      tick(0, 1, 1);
      for (int k = 0; k < 4; k++) tick(0, 0, 1);
      if (g == 99)  chk("sat_100", glitch_cnt, 8'd100);
      if (g == 299) chk("sat_300", glitch_cnt, 8'hFF);
    end
    chk("sat_hold", glitch_cnt, 8'hFF);
    chk("sat_dout", outs(), 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // rise and fall must never overlap
  always @(negedge clk) begin
    if (rise && fall) begin
      checks++;
      errors++;
      $display("FAIL rise_fall_overlap: got rise=%b fall=%b expected not both high", rise, fall);
    end
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw asynchronous input (push-button, switch, external strobe) into a clean, single-clock-domain level with edge pulses.
- Sits directly upstream of the DFF/register stage. `dout` drives its `D` input; `rise`/`fall` serve as one-shot event strobes.
- Structure: multi-flop synchronizer, then a counter-based debounce FSM that accepts a level change only after it has been stable for a programmed number of samples.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive qualifying samples required to accept a new level; must be >= 2.
- RESET_LEVEL, 1'b0, value loaded into synchronizer flops and `dout` on reset.
- Internal counter width = $clog2(DEBOUNCE_CYCLES); it is a localparam, not user-settable.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- din  input  1  raw asynchronous input.
- sample_en  input  1  qualifies FSM/counter updates (prescaler tick); tie to 1 for per-clock sampling.
- dout  output  1  debounced level.
- rise  output  1  one-cycle pulse when `dout` goes 0->1.
- fall  output  1  one-cycle pulse when `dout` goes 1->0.
- busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset: evaluated on the rising edge of `clk` while `rst`=1; overrides all other activity.
  - All sync flops and `dout` load RESET_LEVEL.
  - Counter = 0, state = STABLE, `rise`/`fall`/`busy` = 0.
- Reset mid-qualification: aborts the qualification without any pulse.
- Synchronizer: a shift chain of SYNC_STAGES flops that runs every clock, independent of `sample_en`. Its last stage is `s`.
- FSM states: STABLE and QUALIFY. All updates below occur only on cycles with `sample_en`=1; with `sample_en`=0, state, counter and `dout` hold.
  - STABLE, `s`==`dout`: stay in STABLE, counter=0.
  - STABLE, `s`!=`dout`: go to QUALIFY, counter=1.
  - QUALIFY, `s`==`dout` (glitch): return to STABLE, counter=0, `dout` unchanged, no pulse.
  - QUALIFY, `s`!=`dout` and counter==DEBOUNCE_CYCLES-1: `dout`<=`s`, go to STABLE, counter=0, assert `rise` or `fall` for one cycle.
  - QUALIFY, otherwise: counter+1.
- `busy` is registered; it equals 1 exactly while state==QUALIFY.
- Latency with `sample_en`=1: if clock edge k is the first to sample the new `din` level, `dout` changes at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. `rise`/`fall` assert in the same cycle `dout` changes.
- Pulse duration: `rise` and `fall` last exactly one `clk` cycle, even when the next `sample_en` is far away. They are never both high.
- Counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap.
- A new qualification can start on the sample immediately after an acceptance.

Optional Feature:
- Macro: DEBOUNCE_SYNC_GLITCH_CNT_EN.
- When defined:
  - Adds output port `glitch_cnt` [7:0].
  - Increments by 1 on every QUALIFY->STABLE abort (glitch), saturating at 8'hFF.
  - Cleared by `rst`.
  - Accepted level changes do not increment it.
- When undefined: no port, no counter logic. Core behaviour is identical in both builds.

Test Plan:
- Reset: hold `rst`=1 for 2 cycles with `din`=1 (RESET_LEVEL=0) -> `dout`=0, `rise`=`fall`=`busy`=0; after release, `dout` rises exactly SYNC_STAGES+DEBOUNCE_CYCLES-1 = 5 edges after `din` is first sampled high, with `rise`=1 for 1 cycle.
- Glitch reject: `din` high for 2 cycles then low (`dout`=0) -> `busy` pulses high, `dout` stays 0, no `rise`; `glitch_cnt`=1 when the macro is defined.
- Release: from `dout`=1, drive `din`=0 steady -> `dout`=0 after 5 edges, `fall`=1 for exactly 1 cycle, `busy` deasserts the same cycle.
- Prescaled: `sample_en`=1 every 4th clock, `din` 0->1 -> `dout` rises after the sync delay plus 4 qualifying `sample_en` ticks; `rise` width is 1 `clk`.
- Reset mid-qualify: assert `rst` while `busy`=1 with counter=2 -> next cycle `busy`=0, `dout`=RESET_LEVEL, no `rise`/`fall`.
- Saturation (macro defined): 300 isolated glitches -> `glitch_cnt`=8'hFF and it stays there.
